// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: main control FSM for the multicycle MIPS datapath
module mcycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_src,
   output logic       pc_en,
   output logic       instr_done,
   output logic       trap,
   output logic [3:0] state
);
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_ILLEGAL = 4'd12
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   state_t r_state;
   state_t w_next;
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next;
   end
   assign state = r_state;
   // outputs stay 0 throughout reset; unreachable encodings fall to the default
   always_comb begin
      w_next     = S_FETCH;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      pc_en      = 1'b0;
      instr_done = 1'b0;
      trap       = 1'b0;
      if (rst_n) begin
         case (r_state)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_en     = mem_ready;
               w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
               case (op)
                  OP_LW, OP_SW:   w_next = S_MEMADR;
                  OP_RTYPE:       w_next = S_EXECUTE;
                  OP_BEQ, OP_BNE: w_next = S_BRANCH;
                  OP_ADDI:        w_next = S_ADDIEX;
                  OP_J:           w_next = S_JUMP;
                  default:        w_next = S_ILLEGAL;
               endcase
            end
            S_MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               w_next  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWR: begin
               mem_req    = 1'b1;
               mem_we     = 1'b1;
               iord       = 1'b1;
               instr_done = mem_ready;
               w_next     = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
               alu_src_a = 1'b1;
               alu_op    = 2'b10;
               w_next    = S_ALUWB;
            end
            S_ALUWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a  = 1'b1;
               alu_op     = 2'b01;
               pc_src     = 2'b01;
               pc_en      = (op == OP_BNE) ? !zero : zero;
               instr_done = 1'b1;
            end
            S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_JUMP: begin
               pc_src     = 2'b10;
               pc_en      = 1'b1;
               instr_done = 1'b1;
            end
            S_ILLEGAL: trap = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: directed checks of state sequence and full output vector per cycle
module tb_mcycle_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_we, iord, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic       pc_en, instr_done, trap;
   logic [3:0] state;
   logic [16:0] outs;
   int n_tests = 0;
   int n_fail  = 0;
   mcycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_src(pc_src), .pc_en(pc_en), .instr_done(instr_done), .trap(trap),
      .state(state)
   );
   always #5 clk = ~clk;
   // mr we io ir rd m2r rw sa sb ao ps pe dn tr
   assign outs = {mem_req, mem_we, iord, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_src, pc_en, instr_done, trap};
   localparam logic [16:0] O_ZERO    = 17'b0;
   localparam logic [16:0] O_FETCH_W = 17'b1_0_0_0_0_0_0_0_01_00_00_0_0_0;
   localparam logic [16:0] O_FETCH_R = 17'b1_0_0_1_0_0_0_0_01_00_00_1_0_0;
   localparam logic [16:0] O_DECODE  = 17'b0_0_0_0_0_0_0_0_11_00_00_0_0_0;
   localparam logic [16:0] O_MEMADR  = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
   localparam logic [16:0] O_MEMRD   = 17'b1_0_1_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [16:0] O_MEMWB   = 17'b0_0_0_0_0_1_1_0_00_00_00_0_1_0;
   localparam logic [16:0] O_MEMWR_W = 17'b1_1_1_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [16:0] O_MEMWR_R = 17'b1_1_1_0_0_0_0_0_00_00_00_0_1_0;
   localparam logic [16:0] O_EXECUTE = 17'b0_0_0_0_0_0_0_1_00_10_00_0_0_0;
   localparam logic [16:0] O_ALUWB   = 17'b0_0_0_0_1_0_1_0_00_00_00_0_1_0;
   localparam logic [16:0] O_BR_TK   = 17'b0_0_0_0_0_0_0_1_00_01_01_1_1_0;
   localparam logic [16:0] O_BR_NT   = 17'b0_0_0_0_0_0_0_1_00_01_01_0_1_0;
   localparam logic [16:0] O_ADDIEX  = 17'b0_0_0_0_0_0_0_1_10_00_00_0_0_0;
   localparam logic [16:0] O_ADDIWB  = 17'b0_0_0_0_0_0_1_0_00_00_00_0_1_0;
   localparam logic [16:0] O_JUMP    = 17'b0_0_0_0_0_0_0_0_00_00_10_1_1_0;
   localparam logic [16:0] O_ILLEGAL = 17'b0_0_0_0_0_0_0_0_00_00_00_0_0_1;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, ADDI = 6'b001000;
   localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
   // one cycle: drive inputs, check state and outputs, then advance past the next edge
   task automatic cyc(input logic rst_v, input logic rdy, input logic z, input logic [5:0] op_v,
                      input logic [3:0] es, input logic [16:0] eo, input string tag);
      rst_n = rst_v; mem_ready = rdy; zero = z; op = op_v;
      #2;
      n_tests++;
      assert (state === es) else begin
         n_fail++;
         $error("FAIL %s state: got %0d expected %0d", tag, state, es);
      end
      n_tests++;
      assert (outs === eo) else begin
         n_fail++;
         $error("FAIL %s outs: got %b expected %b", tag, outs, eo);
      end
      @(posedge clk); #1;
   endtask
   initial begin
      rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'b0;
      @(posedge clk); #1;
      cyc(0, 1, 0, RT, 0, O_ZERO, "rst0");
      cyc(0, 1, 0, RT, 0, O_ZERO, "rst1");
      cyc(0, 1, 0, RT, 0, O_ZERO, "rst2");
      cyc(1, 0, 0, LW, 0, O_FETCH_W, "lw_f0");
      cyc(1, 0, 0, LW, 0, O_FETCH_W, "lw_f1");
      cyc(1, 1, 0, LW, 0, O_FETCH_R, "lw_f2");
      cyc(1, 1, 0, LW, 1, O_DECODE, "lw_dec");
      cyc(1, 1, 0, LW, 2, O_MEMADR, "lw_adr");
      cyc(1, 0, 0, LW, 3, O_MEMRD, "lw_rd0");
      cyc(1, 1, 0, LW, 3, O_MEMRD, "lw_rd1");
      cyc(1, 1, 0, LW, 4, O_MEMWB, "lw_wb");
      cyc(1, 1, 0, RT, 0, O_FETCH_R, "r_f");
      cyc(1, 1, 0, RT, 1, O_DECODE, "r_dec");
      cyc(1, 1, 0, RT, 6, O_EXECUTE, "r_ex");
      cyc(1, 1, 0, RT, 7, O_ALUWB, "r_wb");
      cyc(1, 1, 0, ADDI, 0, O_FETCH_R, "ai_f");
      cyc(1, 1, 0, ADDI, 1, O_DECODE, "ai_dec");
      cyc(1, 1, 0, ADDI, 9, O_ADDIEX, "ai_ex");
      cyc(1, 1, 0, ADDI, 10, O_ADDIWB, "ai_wb");
      cyc(1, 1, 1, BEQ, 0, O_FETCH_R, "beq1_f");
      cyc(1, 1, 1, BEQ, 1, O_DECODE, "beq1_dec");
      cyc(1, 1, 1, BEQ, 8, O_BR_TK, "beq1_br");
      cyc(1, 1, 0, BEQ, 0, O_FETCH_R, "beq0_f");
      cyc(1, 1, 0, BEQ, 1, O_DECODE, "beq0_dec");
      cyc(1, 1, 0, BEQ, 8, O_BR_NT, "beq0_br");
      cyc(1, 1, 0, BNE, 0, O_FETCH_R, "bne0_f");
      cyc(1, 1, 0, BNE, 1, O_DECODE, "bne0_dec");
      cyc(1, 1, 0, BNE, 8, O_BR_TK, "bne0_br");
      cyc(1, 1, 1, BNE, 0, O_FETCH_R, "bne1_f");
      cyc(1, 1, 1, BNE, 1, O_DECODE, "bne1_dec");
      cyc(1, 1, 1, BNE, 8, O_BR_NT, "bne1_br");
      cyc(1, 1, 0, SW, 0, O_FETCH_R, "sw_f");
      cyc(1, 1, 0, SW, 1, O_DECODE, "sw_dec");
      cyc(1, 1, 0, SW, 2, O_MEMADR, "sw_adr");
      cyc(1, 0, 0, SW, 5, O_MEMWR_W, "sw_wr0");
      cyc(1, 1, 0, SW, 5, O_MEMWR_R, "sw_wr1");
      cyc(1, 1, 0, J, 0, O_FETCH_R, "j_f");
      cyc(1, 1, 0, J, 1, O_DECODE, "j_dec");
      cyc(1, 1, 0, J, 11, O_JUMP, "j_jmp");
      cyc(1, 1, 0, 6'b111111, 0, O_FETCH_R, "ill_f");
      cyc(1, 1, 0, 6'b111111, 1, O_DECODE, "ill_dec");
      cyc(1, 1, 0, 6'b111111, 12, O_ILLEGAL, "ill_trap");
      cyc(1, 1, 0, 6'b000011, 0, O_FETCH_R, "ill2_f");
      cyc(1, 1, 0, 6'b000011, 1, O_DECODE, "ill2_dec");
      cyc(1, 1, 0, 6'b000011, 12, O_ILLEGAL, "ill2_trap");
      cyc(1, 1, 0, LW, 0, O_FETCH_R, "mr_f");
      cyc(1, 1, 0, LW, 1, O_DECODE, "mr_dec");
      cyc(1, 1, 0, LW, 2, O_MEMADR, "mr_adr");
      cyc(1, 0, 0, LW, 3, O_MEMRD, "mr_rd");
      cyc(0, 0, 0, LW, 3, O_ZERO, "mr_rst");
      cyc(1, 0, 0, LW, 0, O_FETCH_W, "mr_after");
      cyc(1, 1, 0, LW, 0, O_FETCH_R, "mr_after2");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
